// File: rtl/psw_ctx.sv
// Program Status Word with a DEPTH-entry shadow LIFO that saves and restores PSW[7:1]
// on interrupt entry and exit. Define PSW_CTX_PARITY_REG_EN to register the parity bit.
module psw_ctx #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ACC_W = 8,
  localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_byte,
  input  logic             i_wr_bit,
  input  logic             i_wr_flags,
  input  logic [7:0]       i_byte,
  input  logic [2:0]       i_bit_addr,
  input  logic             i_bit_val,
  input  logic             i_cy,
  input  logic             i_ac,
  input  logic             i_ov,
  input  logic [ACC_W-1:0] i_acc,
  input  logic             i_save,
  input  logic             i_restore,
  input  logic             i_err_clr,
  output logic [7:0]       o_psw,
  output logic [1:0]       o_bank,
  output logic [DW-1:0]    o_depth,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
);

  localparam logic [DW-1:0] DepthMax = DW'(DEPTH);

  logic [7:1]    psw_q, psw_d;
  logic [7:1]    stack_q [DEPTH];
  logic [7:1]    stack_d [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;

  logic [7:1]    psw_wr;
  logic [7:0]    bit_wr;
  logic [7:1]    top_entry;
  logic          full, empty;
  logic          do_push, do_pop, err_evt;
  logic          parity;

  assign full  = (depth_q == DepthMax);
  assign empty = (depth_q == '0);

  // Write mux: byte beats bit beats flags. Bit 0 is never stored, so writes to it vanish.
  always_comb begin
    psw_wr = psw_q;
    bit_wr = {psw_q, 1'b0};
    if (i_wr_byte) begin
      psw_wr = i_byte[7:1];
    end else if (i_wr_bit) begin
      bit_wr[i_bit_addr] = i_bit_val;
      psw_wr             = bit_wr[7:1];
    end else if (i_wr_flags) begin
      psw_wr[7] = i_cy;
      psw_wr[6] = i_ac;
      psw_wr[2] = i_ov;
    end
  end

  // Simultaneous save and restore is treated as a collision: no stack movement at all.
  always_comb begin
    do_push = i_save & ~i_restore & ~full;
    do_pop  = i_restore & ~i_save & ~empty;
    err_evt = (i_save & i_restore) | (i_save & full) | (i_restore & empty);
  end

  always_comb begin
    top_entry = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (DW'(i + 1) == depth_q) begin
        top_entry = stack_q[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (do_push && (DW'(i) == depth_q)) begin
        stack_d[i] = psw_q;
      end
    end
  end

  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + 1'b1;
    end else if (do_pop) begin
      depth_d = depth_q - 1'b1;
    end
  end

  // Restore overrides any same-cycle write; a push saves the pre-write value.
  always_comb begin
    psw_d = do_pop ? top_entry : psw_wr;
  end

  always_comb begin
    err_d = err_evt | (err_q & ~i_err_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      psw_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      psw_q   <= psw_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

`ifdef PSW_CTX_PARITY_REG_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = ^i_acc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`else
  assign parity = ^i_acc;
`endif

  assign o_psw   = {psw_q, parity};
  assign o_bank  = psw_q[4:3];
  assign o_depth = depth_q;
  assign o_full  = full;
  assign o_empty = empty;
  assign o_err   = err_q;

`ifndef SYNTHESIS
  a_depth_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n) depth_q <= DepthMax);
  a_push_pop_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(do_push && do_pop));
`endif

endmodule
